// File: rtl/pbit_field_accum.sv
// Local-field accumulator for one p-bit: I = h + sum_j(J_j * m_j), sign-magnitude,
// saturating on magnitude overflow. One term per accepted handshake, K terms per run.
module pbit_field_accum #(
  parameter int Q     = 15,
  parameter int N     = 32,
  parameter int K     = 8,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] bias,
  input  logic         term_valid,
  output logic         term_ready,
  input  logic [N-1:0] weight_in,
  input  logic         spin_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] field,
  output logic         sat
);

  generate
    if (K < 1 || (2 ** CNT_W) <= K || Q >= N - 1) begin : g_bad_params
      $error("pbit_field_accum: invalid K/CNT_W/Q");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t         r_state, w_next;
  logic [N-1:0]   r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic           r_sat_int;
  logic [N-1:0]   r_field;
  logic           r_sat;

  logic           w_accept, w_last;
  logic           w_a_sign, w_c_sign, w_r_sign, w_ovf;
  logic [N-2:0]   w_a_mag, w_c_mag, w_r_mag;
  logic [N-1:0]   w_sum;
  logic [N-1:0]   w_res;
  logic [N-1:0]   w_bias_n;

  assign w_accept = term_valid & term_ready;
  assign w_last   = (r_cnt == CNT_W'(K - 1));

  // Spin -1 flips the weight sign; a zero magnitude always carries sign 0.
  assign w_a_sign = r_acc[N-1];
  assign w_a_mag  = r_acc[N-2:0];
  assign w_c_mag  = weight_in[N-2:0];
  assign w_c_sign = (weight_in[N-1] ^ ~spin_in) & (|w_c_mag);
  assign w_bias_n = {bias[N-1] & (|bias[N-2:0]), bias[N-2:0]};
  assign w_sum    = {1'b0, w_a_mag} + {1'b0, w_c_mag};

  always_comb begin
    w_ovf    = 1'b0;
    w_r_mag  = '0;
    w_r_sign = 1'b0;
    if (w_a_sign == w_c_sign) begin
      w_r_sign = w_a_sign;
      if (w_sum[N-1]) begin
        w_r_mag = '1;
        w_ovf   = 1'b1;
      end else begin
        w_r_mag = w_sum[N-2:0];
      end
    end else if (w_a_mag > w_c_mag) begin
      w_r_mag  = w_a_mag - w_c_mag;
      w_r_sign = w_a_sign;
    end else if (w_c_mag > w_a_mag) begin
      w_r_mag  = w_c_mag - w_a_mag;
      w_r_sign = w_c_sign;
    end
    if (w_r_mag == '0) w_r_sign = 1'b0;
  end

  assign w_res = {w_r_sign, w_r_mag};

  always_comb begin
    w_next     = r_state;
    term_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ACCUM;
      end
      S_ACCUM: begin
        term_ready = 1'b1;
        busy       = 1'b1;
        if (w_accept && w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sat_int <= 1'b0;
      r_field   <= '0;
      r_sat     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc     <= w_bias_n;
            r_cnt     <= '0;
            r_sat_int <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc     <= w_res;
            r_cnt     <= r_cnt + 1'b1;
            r_sat_int <= r_sat_int | w_ovf;
            // Result is latched on the final accept so it is visible during DONE.
            if (w_last) begin
              r_field <= w_res;
              r_sat   <= r_sat_int | w_ovf;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign field = r_field;
  assign sat   = r_sat;

endmodule

// File: tb/tb_pbit_field_accum.sv
// Scoreboard bench for pbit_field_accum: expected field/sat from an integer model
// are queued at stimulus time and popped when done pulses.
module tb_pbit_field_accum;
  localparam int N = 32;
  localparam int K = 8;
  localparam longint MAXM = 64'h7FFF_FFFF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] bias = '0;
  logic         term_valid = 1'b0;
  logic         term_ready;
  logic [N-1:0] weight_in = '0;
  logic         spin_in = 1'b0;
  logic         busy, done, sat;
  logic [N-1:0] field;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  logic [N-1:0] wv [K];
  logic         sv [K];
  logic [N-1:0] exp_f [$];
  logic         exp_s [$];

  pbit_field_accum #(.Q(15), .N(N), .K(K), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .term_valid(term_valid), .term_ready(term_ready),
    .weight_in(weight_in), .spin_in(spin_in),
    .busy(busy), .done(done), .field(field), .sat(sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint sm2int(input logic [31:0] v);
    return v[31] ? -longint'(v[30:0]) : longint'(v[30:0]);
  endfunction

  function automatic logic [31:0] int2sm(input longint v);
    logic [30:0] m;
    if (v < 0) begin
      m = 31'(-v);
      return {1'b1, m};
    end
    m = 31'(v);
    return {1'b0, m};
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (exp_f.size() == 0) begin
        chk("stray_done", 32'd1, 32'd0);
      end else begin
        chk("field", field, exp_f.pop_front());
        chk("sat", {31'd0, sat}, {31'd0, exp_s.pop_front()});
        chk("busy_in_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic run(input logic [31:0] b, input int gap, input bit poke, input bit lat);
    longint acc;
    bit     s;
    bit     acc_ok;
    int     idx, n, c0;
    acc = sm2int(b);
    s   = 1'b0;
    for (int i = 0; i < K; i++) begin
      acc = acc + (sv[i] ? sm2int(wv[i]) : -sm2int(wv[i]));
      if (acc > MAXM) begin acc = MAXM; s = 1'b1; end
      else if (acc < -MAXM) begin acc = -MAXM; s = 1'b1; end
    end
    exp_f.push_back(int2sm(acc));
    exp_s.push_back(s);

    @(posedge clk); #1;
    start = 1'b1; bias = b; c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; bias = $urandom;
    idx = 0; n = 0;
    while (idx < K && n < 400) begin
      term_valid = (gap == 0) || ($urandom_range(99) >= gap);
      weight_in  = wv[idx];
      spin_in    = sv[idx];
      start      = poke && ($urandom_range(3) == 0);
      if (start) bias = $urandom;
      acc_ok = term_valid && term_ready;
      @(posedge clk); #1;
      n++;
      if (acc_ok) idx++;
    end
    term_valid = 1'b0; start = 1'b0;
    if (idx < K) chk("accept_timeout", idx, K);
    chk("done_after_last", {31'd0, done}, 32'd1);
    if (lat) chk("done_cycle", cyc - c0, K + 1);
    @(posedge clk); #1;
    chk("idle_after", {30'd0, busy, term_ready}, 32'd0);
  endtask

  task automatic fill(input logic [31:0] w, input bit s);
    for (int i = 0; i < K; i++) begin wv[i] = w; sv[i] = s; end
  endtask

  initial begin
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, term_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_field", field, 32'd0);
    chk("rst_sat", {31'd0, sat}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 5.0 with valid held; done must land in cycle K+1
    fill(32'h0000_4000, 1'b1);
    run(32'h0000_8000, 0, 1'b0, 1'b1);

    // alternating spins cancel to +0
    for (int i = 0; i < K; i++) begin wv[i] = 32'h0000_4000; sv[i] = (i % 2 == 0); end
    run(32'h0000_0000, 0, 1'b0, 1'b1);

    // sign crosses zero from -1.0 to +1.0
    fill(32'h0000_2000, 1'b1);
    run(32'h8000_8000, 0, 1'b0, 1'b0);

    // positive and negative saturation
    fill(32'h0000_0000, 1'b1);
    wv[0] = 32'h0000_8000;
    run(32'h7FFF_FFFF, 0, 1'b0, 1'b0);
    fill(32'h0000_0000, 1'b0);
    wv[0] = 32'h0000_8000;
    run(32'hFFFF_FFFF, 0, 1'b0, 1'b0);

    // gapped valid with stray start pulses
    fill(32'h0000_4000, 1'b1);
    run(32'h0000_8000, 40, 1'b1, 1'b0);

    // random weights, including large ones that saturate then recover
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < K; i++) begin
        wv[i] = (r < 3) ? ($urandom & 32'h8000_FFFF) : $urandom;
        sv[i] = $urandom_range(1);
      end
      run($urandom, (r % 2) ? 30 : 0, r[0], 1'b0);
    end

    // reset after 3 accepted terms aborts with no done
    fill(32'h0000_4000, 1'b1);
    @(posedge clk); #1 start = 1'b1; bias = 32'h0000_8000;
    @(posedge clk); #1 start = 1'b0; term_valid = 1'b1;
    weight_in = 32'h0000_4000; spin_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; term_valid = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, term_ready}, 32'd0);
    chk("abort_field", field, 32'd0);
    chk("abort_sat", {31'd0, sat}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    fill(32'h0000_1000, 1'b0);
    run(32'h0000_8000, 0, 1'b0, 1'b1);

    repeat (4) @(posedge clk);
    chk("queue_empty", exp_f.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
